// File: rtl/rs232_reg_responder.sv
// -----------------------------------------------------------------------------
// rs232_reg_responder
//
// Responder for the 3-byte serial command protocol (flow, address, data).
// Receives bytes from a UART, turns each complete frame into a single access
// on the internal register bus, and for read frames returns the register
// value as one byte through the UART transmitter.
//
//   flow = 0x00 : write frame -> one REG_WE pulse with REG_ADDR / REG_WDATA
//   flow = 0x01 : read frame  -> one REG_RE pulse, REG_RDATA captured and sent
//
// Parameters
//   TIMEOUT_CYCLES  max clocks between two bytes of one frame (>= 2)
//   RD_LATENCY      clocks from REG_RE to valid REG_RDATA (1..4)
//
// Ports
//   CLK_50MHZ  in   clock, everything on the rising edge
//   RST        in   synchronous active-low reset
//   RX_DONE    in   one-cycle strobe, RX_DATA holds a received byte
//   RX_DATA    in   received byte
//   TX_BUSY    in   UART transmitter busy
//   TX_TRG     out  one-cycle strobe, UART sends TX_DATA
//   TX_DATA    out  byte to transmit (held until next read response)
//   REG_ADDR   out  register address (held until next frame executes)
//   REG_WDATA  out  register write data (held like REG_ADDR)
//   REG_WE     out  one-cycle write strobe
//   REG_RE     out  one-cycle read strobe
//   REG_RDATA  in   register read data
//   FRAME_ERR  out  one-cycle strobe: bad flow byte, timeout or dropped byte
// -----------------------------------------------------------------------------
module rs232_reg_responder #(
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int RD_LATENCY     = 1
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       RX_DONE,
    input  logic [7:0] RX_DATA,
    input  logic       TX_BUSY,
    output logic       TX_TRG,
    output logic [7:0] TX_DATA,
    output logic [7:0] REG_ADDR,
    output logic [7:0] REG_WDATA,
    output logic       REG_WE,
    output logic       REG_RE,
    input  logic [7:0] REG_RDATA,
    output logic       FRAME_ERR
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    // The error strobe is registered, so the decision is taken one clock
    // early: the counter reads TIMEOUT_CYCLES-2 in the last waiting clock.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);
    localparam logic [1:0]      RD_LAST = 2'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_ADDR = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_EXEC      = 3'd3,
        ST_RD_WAIT   = 3'd4,
        ST_TX_REQ    = 3'd5
    } state_t;

    state_t          state_q,     state_d;
    logic            is_read_q,   is_read_d;
    logic [7:0]      addr_buf_q,  addr_buf_d;
    logic [7:0]      reg_addr_q,  reg_addr_d;
    logic [7:0]      reg_wdata_q, reg_wdata_d;
    logic            reg_we_q,    reg_we_d;
    logic            reg_re_q,    reg_re_d;
    logic [7:0]      tx_data_q,   tx_data_d;
    logic            tx_trg_q,    tx_trg_d;
    logic            frame_err_q, frame_err_d;
    logic [TO_W-1:0] to_cnt_q,    to_cnt_d;
    logic [1:0]      rd_cnt_q,    rd_cnt_d;

    always_ff @(posedge CLK_50MHZ) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            is_read_q   <= 1'b0;
            addr_buf_q  <= 8'd0;
            reg_addr_q  <= 8'd0;
            reg_wdata_q <= 8'd0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            tx_data_q   <= 8'd0;
            tx_trg_q    <= 1'b0;
            frame_err_q <= 1'b0;
            to_cnt_q    <= '0;
            rd_cnt_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            is_read_q   <= is_read_d;
            addr_buf_q  <= addr_buf_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            tx_data_q   <= tx_data_d;
            tx_trg_q    <= tx_trg_d;
            frame_err_q <= frame_err_d;
            to_cnt_q    <= to_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        is_read_d   = is_read_q;
        addr_buf_d  = addr_buf_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        tx_data_d   = tx_data_q;
        tx_trg_d    = 1'b0;
        frame_err_d = 1'b0;
        to_cnt_d    = to_cnt_q;
        rd_cnt_d    = rd_cnt_q;

        case (state_q)
            ST_IDLE: begin
                to_cnt_d = '0;
                if (RX_DONE) begin
                    if (RX_DATA[7:1] == 7'd0) begin
                        is_read_d = RX_DATA[0];
                        state_d   = ST_WAIT_ADDR;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end

            ST_WAIT_ADDR: begin
                if (RX_DONE) begin
                    addr_buf_d = RX_DATA;
                    to_cnt_d   = '0;
                    state_d    = ST_WAIT_DATA;
                end else if (to_cnt_q == TO_LAST) begin
                    frame_err_d = 1'b1;
                    to_cnt_d    = '0;
                    state_d     = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            ST_WAIT_DATA: begin
                if (RX_DONE) begin
                    // Bus outputs and the strobe are registered on the edge
                    // that enters EXEC, so they are visible during EXEC,
                    // one clock after the third byte.
                    reg_addr_d = addr_buf_q;
                    to_cnt_d   = '0;
                    if (is_read_q) begin
                        reg_re_d = 1'b1;
                    end else begin
                        reg_wdata_d = RX_DATA;
                        reg_we_d    = 1'b1;
                    end
                    state_d = ST_EXEC;
                end else if (to_cnt_q == TO_LAST) begin
                    frame_err_d = 1'b1;
                    to_cnt_d    = '0;
                    state_d     = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            ST_EXEC: begin
                frame_err_d = RX_DONE;
                rd_cnt_d    = 2'd0;
                state_d     = is_read_q ? ST_RD_WAIT : ST_IDLE;
            end

            ST_RD_WAIT: begin
                frame_err_d = RX_DONE;
                if (rd_cnt_q == RD_LAST) begin
                    tx_data_d = REG_RDATA;
                    // Fire straight away when the transmitter is free so the
                    // response leaves RD_LATENCY+2 clocks after the last byte.
                    if (!TX_BUSY) begin
                        tx_trg_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_TX_REQ;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + 2'd1;
                end
            end

            ST_TX_REQ: begin
                frame_err_d = RX_DONE;
                if (!TX_BUSY) begin
                    tx_trg_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign TX_TRG    = tx_trg_q;
    assign TX_DATA   = tx_data_q;
    assign REG_ADDR  = reg_addr_q;
    assign REG_WDATA = reg_wdata_q;
    assign REG_WE    = reg_we_q;
    assign REG_RE    = reg_re_q;
    assign FRAME_ERR = frame_err_q;

endmodule
